// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the ALU round-robin scheduler.
//   state_t : scheduler FSM encoding (IDLE / EXEC / RESP)
//   DATA_W, SEL_W, OUT_W : default operand, select and result widths
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W = 4;
  localparam int SEL_W  = 3;
  localparam int OUT_W  = 6;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between NUM_REQ requesters and the scheduler.
//   req_valid/req_ready   : per-lane request handshake (ready is one-hot or zero)
//   req_a/req_b/req_c     : packed operands, lane i at [i*DATA_W +: DATA_W]
//   req_sel               : packed select codes, lane i at [i*SEL_W +: SEL_W]
//   resp_valid/resp_ready : per-lane response handshake (valid is one-hot or zero)
//   resp_data             : result shared by all lanes
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high for the same lane; the sender holds valid and payload
// stable until that edge, and ready may depend combinationally on valid.
// Modports: master = requester side, slave = scheduler side.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 4,
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 6
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_c;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [OUT_W-1:0]          resp_data;

  modport master (
    output req_valid, req_a, req_b, req_c, req_sel, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_sel, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request vector
//   ptr     : lane with highest priority this cycle
//   grant   : one-hot winner (zero when no request)
//   gnt_idx : binary index of the winner
//   any_req : at least one request present
// Search runs from ptr upward and wraps, so the first set bit wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   gnt_idx,
  output logic               any_req
);
  int idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req      = 1'b1;
        grant[idx]   = 1'b1;
        gnt_idx      = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU among NUM_REQ requesters.
// A request is granted round-robin in IDLE, its operands are registered and
// driven to the ALU during EXEC, the result is captured and returned to the
// granted lane in RESP. One operation in flight at a time.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : request/response channel (see alu_rr_scheduler_if)
//   alu_a/b/c      : registered operands to the ALU
//   alu_select     : registered select to the ALU
//   alu_out        : ALU result
//   busy           : high whenever the FSM is not in IDLE
//   op_count       : completed responses, saturating (0 unless feature on)
//   dbg_state      : FSM state encoding
//   dbg_rr_ptr     : round-robin pointer, zero-extended to 2 bits
// Optional feature macro: ALU_SCHED_PERF_EN enables the op_count counter.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = alu_sched_pkg::DATA_W,
  parameter int SEL_W   = alu_sched_pkg::SEL_W,
  parameter int OUT_W   = alu_sched_pkg::OUT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_rr_scheduler_if.slave   bus,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [DATA_W-1:0]   alu_c,
  output logic [SEL_W-1:0]    alu_select,
  input  logic [OUT_W-1:0]    alu_out,
  output logic                busy,
  output logic [15:0]         op_count,
  output logic [1:0]          dbg_state,
  output logic [1:0]          dbg_rr_ptr
);
  import alu_sched_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state, w_next;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_gnt;
  logic [DATA_W-1:0]    r_a, r_b, r_c;
  logic [SEL_W-1:0]     r_sel;
  logic [OUT_W-1:0]     r_result;

  logic [NUM_REQ-1:0]   w_grant;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic                 w_any;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req     (bus.req_valid),
    .ptr     (r_rr_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .any_req (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // req_ready is gated by rst_n so that every output is zero while reset is held.
  always_comb begin
    w_next         = r_state;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    w_load         = 1'b0;
    w_capture      = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && rst_n) begin
          bus.req_ready = w_grant;
          w_load        = 1'b1;
          w_next        = EXEC;
        end
      end
      EXEC: begin
        w_capture = 1'b1;
        w_next    = RESP;
      end
      RESP: begin
        bus.resp_valid = NUM_REQ'(1) << r_gnt;
        if (bus.resp_ready[r_gnt]) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_sel    <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_gnt    <= w_gnt_idx;
        r_a      <= bus.req_a[w_gnt_idx*DATA_W +: DATA_W];
        r_b      <= bus.req_b[w_gnt_idx*DATA_W +: DATA_W];
        r_c      <= bus.req_c[w_gnt_idx*DATA_W +: DATA_W];
        r_sel    <= bus.req_sel[w_gnt_idx*SEL_W +: SEL_W];
        r_rr_ptr <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_capture) r_result <= alu_out;
    end
  end

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] r_op_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_op_count <= '0;
    else if (w_done && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
  end
  assign op_count = r_op_count;
`else
  assign op_count = 16'h0000;
`endif

  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_c         = r_c;
  assign alu_select    = r_sel;
  assign bus.resp_data = r_result;
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;
  assign dbg_rr_ptr    = 2'(r_rr_ptr);
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with two requesters and an a+b+c ALU stub.
module tb_alu_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.NUM_REQ(2), .DATA_W(4), .SEL_W(3), .OUT_W(6)) bus ();

  logic [3:0]  alu_a, alu_b, alu_c;
  logic [2:0]  alu_select;
  logic [5:0]  alu_out;
  logic        busy;
  logic [15:0] op_count;
  logic [1:0]  dbg_state, dbg_rr_ptr;

  assign alu_out = 6'(alu_a) + 6'(alu_b) + 6'(alu_c);

  alu_rr_scheduler #(.NUM_REQ(2), .DATA_W(4), .SEL_W(3), .OUT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_select (alu_select),
    .alu_out    (alu_out),
    .busy       (busy),
    .op_count   (op_count),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic set_lane(input int l, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [2:0] s);
    bus.req_a[l*4 +: 4]   = a;
    bus.req_b[l*4 +: 4]   = b;
    bus.req_c[l*4 +: 4]   = c;
    bus.req_sel[l*3 +: 3] = s;
  endtask

  // Waits (bounded) for any resp_valid; lat = negedges seen, -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
    n_vec++; if (bus.resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b want 00", bus.resp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if ({alu_a, alu_b, alu_c, alu_select} !== 15'h0) begin n_err++; $display("FAIL reset_alu: got %h want 0", {alu_a, alu_b, alu_c, alu_select}); end
    n_vec++; if (bus.resp_data !== 6'd0) begin n_err++; $display("FAIL reset_resp_data: got %0d want 0", bus.resp_data); end
    n_vec++; if (op_count !== 16'h0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    n_vec++; if ({dbg_state, dbg_rr_ptr} !== 4'h0) begin n_err++; $display("FAIL reset_state_ptr: got %h want 0", {dbg_state, dbg_rr_ptr}); end
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_lane(0, 4'd13, 4'd12, 4'd14, 3'd7);
    bus.req_valid = 2'b01;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    n_vec++; if (alu_select !== 3'd7 || alu_a !== 4'd13) begin n_err++; $display("FAIL single_alu: got sel %0d a %0d want sel 7 a 13", alu_select, alu_a); end
    n_vec++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin n_err++; $display("FAIL single_exec: got busy %b state %0d want 1 1", busy, dbg_state); end
    n_vec++; if (bus.resp_valid !== 2'b00) begin n_err++; $display("FAIL single_early_resp: got %b want 00", bus.resp_valid); end
    @(negedge clk);
    n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 6'd39) begin n_err++; $display("FAIL single_resp: got %b/%0d want 01/39", bus.resp_valid, bus.resp_data); end
    n_vec++; if (busy !== 1'b1 || dbg_state !== 2'd2) begin n_err++; $display("FAIL single_resp_state: got busy %b state %0d want 1 2", busy, dbg_state); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || bus.resp_valid !== 2'b00) begin n_err++; $display("FAIL single_idle: got busy %b resp %b want 0 00", busy, bus.resp_valid); end
    n_vec++; if (dbg_rr_ptr !== 2'd1) begin n_err++; $display("FAIL single_rr_ptr: got %0d want 1", dbg_rr_ptr); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int lat;
    pulse_reset();
    set_lane(0, 4'd13, 4'd12, 4'd14, 3'd7);
    set_lane(1, 4'd1, 4'd2, 4'd3, 3'd0);
    bus.req_valid = 2'b11;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL cont_first_grant: got %b want 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b10;
    wait_resp(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL cont_latency0: got %0d want 2", lat); end
    n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 6'd39) begin n_err++; $display("FAIL cont_resp0: got %b/%0d want 01/39", bus.resp_valid, bus.resp_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b10 || busy !== 1'b0) begin n_err++; $display("FAIL cont_second_grant: got %b busy %b want 10 0", bus.req_ready, busy); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_resp(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL cont_latency1: got %0d want 2", lat); end
    n_vec++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 6'd6) begin n_err++; $display("FAIL cont_resp1: got %b/%0d want 10/6", bus.resp_valid, bus.resp_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (dbg_rr_ptr !== 2'd0 || busy !== 1'b0) begin n_err++; $display("FAIL cont_end: got ptr %0d busy %b want 0 0", dbg_rr_ptr, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.resp_ready = 2'b10;
    bus.req_valid  = 2'b01;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL bp_grant: got %b want 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b10;
    wait_resp(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL bp_latency: got %0d want 2", lat); end
    for (int j = 0; j < 5; j++) begin
      n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 6'd39) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%0d want 01/39", j, bus.resp_valid, bus.resp_data); end
      n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL bp_no_grant[%0d]: got %b want 00", j, bus.req_ready); end
      @(negedge clk);
    end
    bus.resp_ready = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b10) begin n_err++; $display("FAIL bp_next_grant: got %b want 10", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_resp(lat);
    n_vec++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 6'd6) begin n_err++; $display("FAIL bp_resp1: got %b/%0d want 10/6", bus.resp_valid, bus.resp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int lat;
    bus.req_valid = 2'b01;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rst_grant: got %b want 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b10;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin n_err++; $display("FAIL rst_in_exec: got busy %b state %0d want 1 1", busy, dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_async_state: got busy %b state %0d want 0 0", busy, dbg_state); end
    n_vec++; if ({alu_a, alu_b, alu_c, alu_select} !== 15'h0) begin n_err++; $display("FAIL rst_async_alu: got %h want 0", {alu_a, alu_b, alu_c, alu_select}); end
    n_vec++; if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_async_hs: got %b %b want 00 00", bus.req_ready, bus.resp_valid); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if (bus.resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_no_resp[%0d]: got %b want 00", k, bus.resp_valid); end
    end
    bus.req_valid = 2'b11;
    #1;
    n_vec++; if (bus.req_ready !== 2'b01) begin n_err++; $display("FAIL rst_lowest_grant: got %b want 01", bus.req_ready); end
    @(posedge clk); #1 bus.req_valid = 2'b00;
    wait_resp(lat);
    n_vec++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 6'd39) begin n_err++; $display("FAIL rst_resp: got %b/%0d want 01/39", bus.resp_valid, bus.resp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    int lat;
    int l;
    int k;
    logic [5:0] exp_sum [2];
    logic [5:0] exp_now;
    logic [3:0] a, b, c;
    pulse_reset();
    for (int ln = 0; ln < 2; ln++) begin
      a = 4'(ln + 1); b = 4'(3 * ln); c = 4'(15 - ln);
      set_lane(ln, a, b, c, 3'(ln));
      exp_sum[ln] = 6'(a) + 6'(b) + 6'(c);
    end
    bus.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      l = i % 2;
      @(negedge clk);
      n_vec++; if (bus.req_ready !== 2'(1 << l)) begin n_err++; $display("FAIL fair_grant[%0d]: got %b want %b", i, bus.req_ready, 2'(1 << l)); end
      exp_now = exp_sum[l];
      @(posedge clk); #1;
      k = i + 2;
      if (k < 8) begin
        a = 4'(k + 1); b = 4'(3 * k); c = 4'(15 - k);
        set_lane(l, a, b, c, 3'(k));
        exp_sum[l] = 6'(a) + 6'(b) + 6'(c);
      end else begin
        bus.req_valid[l] = 1'b0;
      end
      @(negedge clk);
      n_vec++; if (alu_select !== 3'(i)) begin n_err++; $display("FAIL fair_sel[%0d]: got %0d want %0d", i, alu_select, i); end
      wait_resp(lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL fair_latency[%0d]: got %0d want 1", i, lat); end
      n_vec++; if (bus.resp_valid !== 2'(1 << l) || bus.resp_data !== exp_now) begin n_err++; $display("FAIL fair_resp[%0d]: got %b/%0d want %b/%0d", i, bus.resp_valid, bus.resp_data, 2'(1 << l), exp_now); end
      @(posedge clk); #1;
    end
    @(negedge clk);
`ifdef ALU_SCHED_PERF_EN
    n_vec++; if (op_count !== 16'd8) begin n_err++; $display("FAIL fair_op_count: got %0d want 8", op_count); end
`else
    n_vec++; if (op_count !== 16'd0) begin n_err++; $display("FAIL fair_op_count: got %0d want 0", op_count); end
`endif
    n_vec++; if (busy !== 1'b0 || bus.req_ready !== 2'b00) begin n_err++; $display("FAIL fair_end: got busy %b ready %b want 0 00", busy, bus.req_ready); end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_c      = '0;
    bus.req_sel    = '0;
    bus.resp_ready = 2'b11;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational F_8_ALU between NUM_REQ requesters.
- Each requester submits an operation: a, b, c (4 bit each) and select (3 bit). The scheduler grants requesters round-robin and drives the shared ALU from registered operands.
- It captures the 6-bit ALU result and returns it to the granted requester over a valid/ready response channel.
- It sits between the requester blocks and the ALU instance. The ALU itself is instantiated outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- DATA_W, 4, width of the a/b/c operands.
- SEL_W, 3, width of the ALU select field.
- OUT_W, 6, width of the ALU result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*DATA_W  packed a operands; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed b operands.
- req_c  in  NUM_REQ*DATA_W  packed c operands.
- req_sel  in  NUM_REQ*SEL_W  packed select codes.
- resp_valid  out  NUM_REQ  result valid for requester i; one-hot or zero.
- resp_data  out  OUT_W  result, shared by all requesters.
- resp_ready  in  NUM_REQ  requester i accepts its result.
- alu_a, alu_b, alu_c  out  DATA_W  operands driven to the ALU.
- alu_select  out  SEL_W  select driven to the ALU.
- alu_out  in  OUT_W  combinational ALU result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-operation count; see Optional Feature.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; rr_ptr=0; grant index=0.
  - Operand regs, alu_* outputs and result reg all 0.
  - resp_valid=0, req_ready=0, busy=0, op_count=0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick winner g = first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready[g] is asserted combinationally in the same cycle.
  - On the handshake edge: latch req_*[g] into operand regs, latch g, rr_ptr <= (g+1) mod NUM_REQ, go to EXEC.
  - If no req_valid is high: stay in IDLE; rr_ptr unchanged.
- EXEC (exactly one cycle):
  - alu_* outputs come from the operand regs. They are held stable from the cycle after the handshake until the next handshake.
  - At the end of the cycle: result reg <= alu_out; go to RESP.
- RESP:
  - resp_valid[g]=1 and resp_data=result reg, held stable until resp_ready[g]=1.
  - On resp_valid[g] && resp_ready[g]: go to IDLE.
  - resp_ready on other lanes is ignored.
- Latency: resp_valid rises 2 cycles after the request handshake edge.
- Minimum issue interval is 3 cycles, because there is no overlap between operations.
- Protocol rule: a requester holds req_valid and its operands stable until req_ready is seen. A requester that drops req_valid before it is granted loses its turn and causes no error.
- Simultaneous valid requests are served in round-robin order starting from rr_ptr. No requester waits more than NUM_REQ-1 grants.
- Widths:
  - No arithmetic is done in this block; alu_out is passed through unmodified.
  - rr_ptr is clog2(NUM_REQ) bits (minimum 1). rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-operation: the in-flight operation is dropped and no response is issued. After rst_n deasserts, the first grant goes to the lowest valid index.
- Back-to-back: the IDLE cycle after a response always occurs. A new grant can happen in that IDLE cycle.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- Defined:
  - op_count increments by 1 on every response handshake (resp_valid && resp_ready).
  - It saturates at 16'hFFFF.
  - It is cleared by reset.
- Undefined: op_count is tied to 16'h0000 and no counter flops are built.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - default width constants: DATA_W=4, SEL_W=3, OUT_W=6.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.
  - The top module owns rr_ptr and the FSM.

Test Plan:
- Common setup for all scenarios: the bench ALU stub drives alu_out = a+b+c (6 bit).
- Single request: req0 with a=13, b=12, c=14, sel=7. Expect:
  - req_ready[0] in the same cycle.
  - alu_select=7 one cycle later.
  - resp_valid[0] and resp_data=39 two cycles after the handshake.
  - busy high for the whole operation.
- Contention: req0 and req1 both valid out of reset; req1 has a=1, b=2, c=3, sel=0. Expect:
  - req0 served first, resp_data=39.
  - req1 granted in the next IDLE, resp_data=6.
  - rr_ptr ends at 0.
- Back-pressure: hold resp_ready[0]=0 for 5 cycles. Expect:
  - resp_valid[0] and resp_data=39 held stable.
  - no new grant, and req_ready=0 on all lanes during RESP.
- Reset mid-op: pulse rst_n low during EXEC. Expect:
  - all outputs 0 immediately, without waiting for a clock edge.
  - no resp_valid after release.
  - next grant goes to the lowest valid index.
- Fairness sweep: both requesters valid for 8 operations, with select stepping 0..7. Expect:
  - strict alternation 0,1,0,1,...
  - each result equal to the stub sum for its operands.
  - with ALU_SCHED_PERF_EN defined, op_count=8.
